// File: rtl/riscv_muldiv_pkg.sv
// Shared types and operation-decode helpers for the RV32M/RV64M multiply/divide unit.
package riscv_muldiv_pkg;

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_rs1(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_rs2(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational datapath slice: UNROLL iterations of shift-add multiply or restoring divide.
module muldiv_step #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN-1:0] h;
    logic [XLEN-1:0] l;
    logic [XLEN:0]   t;

    // Multiply: {hi,lo} holds partial product / remaining multiplier bits.
    // Divide:   {hi,lo} holds partial remainder / dividend shifting into quotient.
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    always_comb begin
        h = hi;
        l = lo;
        t = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (div) begin
                t = {h, l[XLEN-1]};
                l = {l[XLEN-2:0], 1'b0};
                if (t >= {1'b0, operand}) begin
                    t    = t - {1'b0, operand};
                    l[0] = 1'b1;
                end
                h = t[XLEN-1:0];
            end else begin
                t = {1'b0, h} + (l[0] ? {1'b0, operand} : '0);
                l = {t[0], l[XLEN-1:1]};
                h = t[XLEN:1];
            end
        end
        hi_next = h;
        lo_next = l;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with busy hold and tagged result.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1,
    parameter int RD_W   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_e,
    input  logic [2:0]      op_e,
    input  logic [XLEN-1:0] rs1_e,
    input  logic [XLEN-1:0] rs2_e,
    input  logic [RD_W-1:0] rd_addr_e,
    input  logic            flush,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] result_rd
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t   state, state_next;
    muldiv_op_t      op_in, op_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] hi, lo, operand_q, hi_step, lo_step;
    logic            neg_q, neg_rem_q;
    logic [RD_W-1:0] rd_q;
    logic            accept, fast, load_result;
    logic            sign1, sign2;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN-1:0] fast_value, fix_value;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign op_in = muldiv_op_t'(op_e);
    assign sign1 = is_signed_rs1(op_in) & rs1_e[XLEN-1];
    assign sign2 = is_signed_rs2(op_in) & rs2_e[XLEN-1];
    assign mag1  = sign1 ? -rs1_e : rs1_e;
    assign mag2  = sign2 ? -rs2_e : rs2_e;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fm_a, fm_b;
    logic signed [2*XLEN-1:0] fm_prod;
    assign fm_a    = {is_signed_rs1(op_in) & rs1_e[XLEN-1], rs1_e};
    assign fm_b    = {is_signed_rs2(op_in) & rs2_e[XLEN-1], rs2_e};
    assign fm_prod = (2*XLEN)'(fm_a) * (2*XLEN)'(fm_b);
`endif

    // Operations resolved at accept time skip the iterative datapath.
    always_comb begin
        fast       = 1'b0;
        fast_value = '0;
        if (is_div(op_in)) begin
            if (rs2_e == '0) begin
                fast       = 1'b1;
                fast_value = is_rem(op_in) ? rs1_e : '1;
            end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                         rs1_e == MIN_NEG && rs2_e == '1) begin
                fast       = 1'b1;
                fast_value = is_rem(op_in) ? '0 : rs1_e;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            fast       = 1'b1;
            fast_value = (op_in == OP_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: if (start_e && !flush) begin
                accept     = 1'b1;
                state_next = fast ? ST_DONE : ST_CALC;
            end
            ST_CALC: if (cnt == LAST_STEP) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    // DONE is only ever entered from IDLE (fast path) or FIX.
    assign load_result = (state_next == ST_DONE);

    muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
        .div     (is_div(op_q)),
        .hi      (hi),
        .lo      (lo),
        .operand (operand_q),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    assign prod_fix  = neg_q ? -{hi, lo} : {hi, lo};
    assign quo_fix   = neg_q ? -lo : lo;
    assign rem_fix   = neg_rem_q ? -hi : hi;
    assign fix_value = is_div(op_q) ? (is_rem(op_q) ? rem_fix : quo_fix)
                     : (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= OP_MUL;
            rd_q      <= '0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            operand_q <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
            result_rd <= '0;
        end else begin
            if (accept && !fast) begin
                op_q      <= op_in;
                rd_q      <= rd_addr_e;
                cnt       <= '0;
                hi        <= '0;
                lo        <= is_div(op_in) ? mag1 : mag2;
                operand_q <= is_div(op_in) ? mag2 : mag1;
                neg_q     <= sign1 ^ sign2;
                neg_rem_q <= sign1;
            end else if (state == ST_CALC) begin
                hi  <= hi_step;
                lo  <= lo_step;
                cnt <= (cnt == LAST_STEP) ? '0 : cnt + CNT_W'(1);
            end
            if (load_result) begin
                result    <= (state == ST_IDLE) ? fast_value : fix_value;
                result_rd <= (state == ST_IDLE) ? rd_addr_e : rd_q;
            end
        end
    end

    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_DONE);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
- Accepts one operation when idle and computes it iteratively over XLEN/UNROLL steps.
- Drives busy so the DE/EX and FE/DE registers hold while it works.
- Returns a tagged result to be merged into execute_out ahead of EX/MEM.

Parameters:
XLEN, 32, datapath width; 32 or 64.
UNROLL, 1, bits retired per CALC cycle; 1, 2 or 4; must divide XLEN.
RD_W, 5, destination register address width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous active-low reset.
start_e  in  1  operation request; accepted only when state is IDLE and flush is low.
op_e  in  3  funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
rs1_e  in  XLEN  operand 1 (dividend / multiplicand).
rs2_e  in  XLEN  operand 2 (divisor / multiplier).
rd_addr_e  in  RD_W  destination tag.
flush  in  1  abort the in-flight operation (branch taken).
busy  out  1  high whenever state is not IDLE.
result_valid  out  1  one-cycle pulse when result is ready.
result  out  XLEN  operation result.
result_rd  out  RD_W  tag captured at accept.

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0; result_valid=0; result=0; result_rd=0; all internal accumulators and counters are 0.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE to CALC on accept. At accept, capture operand magnitudes, sign flags, op, rd; clear the step counter.
  - CALC runs XLEN/UNROLL cycles. Multiply uses shift-add; divide uses restoring division. Each cycle retires UNROLL bits; the counter wraps to 0 on exit.
  - FIX (1 cycle) applies sign correction and selects the low/high product or quotient/remainder.
  - DONE (1 cycle): result_valid=1, then IDLE.
- Latency: result_valid rises XLEN/UNROLL+2 edges after the accepting edge (34 for XLEN=32, UNROLL=1). busy is high from the edge after accept through DONE inclusive.
- result and result_rd hold their value after DONE until the next DONE.
- Signedness rules:
  - MULH: signed × signed.
  - MULHSU: signed rs1 × unsigned rs2.
  - DIV/REM: signed, truncating toward zero.
  - The remainder takes the sign of the dividend.
  - The full 2·XLEN product is formed internally.
- Fast path (IDLE to DONE directly; result_valid rises 1 edge after accept):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV gives rs1; REM gives 0.
- Start while busy: ignored, no capture. Upstream must hold start_e and operands while busy.
- flush: state goes to IDLE on the next edge from any state.
  - No result_valid for an aborted operation. If flush is high in DONE, result_valid is still produced that cycle.
  - flush and start_e in the same IDLE cycle: flush wins; nothing is accepted.
- Reset asserted mid-operation: immediate return to the reset state. No partial result is ever visible.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational XLEN×XLEN multiplier. IDLE goes to DONE, so result_valid rises 1 edge after accept. Divides are unchanged.
- Undefined: all ops use the iterative CALC path with the latency above. No multiplier array is synthesised.

Decomposition:
- Package riscv_muldiv_pkg:
  - muldiv_op_t enum (funct3 encodings above).
  - muldiv_state_t enum.
  - Function is_div(op).
  - Function is_signed_rs1(op) / is_signed_rs2(op).
- Sub-module muldiv_step:
  - Combinational; performs UNROLL iterations of shift-add or restore-subtract.
  - Instantiated once inside CALC. Keeps the UNROLL generalisation out of the FSM.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD (XLEN=32, UNROLL=1) -> result 0xFFFFFFEB; result_valid exactly 34 edges after accept; busy high throughout.
2. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; result_rd equals the tag given at accept.
4. DIVU 100/0 -> 0xFFFFFFFF, REM 100/0 -> 100, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each with result_valid 1 edge after accept.
5. flush on CALC cycle 10 -> no result_valid; busy low next cycle; new MUL 3×5 accepted the cycle after -> 15. A start_e held during busy is not re-accepted twice.
6. reset low mid-CALC -> outputs 0 immediately. UNROLL=4, XLEN=64 DIV 1000/3 -> 333 after 18 edges. With MULDIV_FAST_MUL_EN, MUL 6×7 -> 42 after 1 edge.
